coefficient_loader_n: RTL and testbench

Parametrised coefficient-load sequencer for the AHB-Lite FIR accelerator. It issues one load_coeff pulse per enabled coefficient slot and waits for the datapath's modwait handshake between loads. It optionally pulses a clear once the set is complete. It extends the fixed 4-tap loader with:
- a configurable tap count
- a per-slot enable mask
- restart on a new request
- a modwait timeout with an error flag

---
 rtl/coefficient_loader_n_if.sv | 40 ++++
 rtl/coefficient_loader_n.sv | 147 ++++++++++++++
 tb/tb_coefficient_loader_n.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coefficient_loader_n_if.sv
// Handshake bundle between the FIR coefficient loader and its requester/datapath.
interface coefficient_loader_n_if #(
    parameter int NUM_COEFFS = 4
);
    localparam int IDX_W = ($clog2(NUM_COEFFS) > 1) ? $clog2(NUM_COEFFS) : 1;

    logic                  new_coefficient_set;
    logic [NUM_COEFFS-1:0] coeff_mask;
    logic                  modwait;
    logic                  load_coeff;
    logic [IDX_W-1:0]      coefficient_num;
    logic                  clear_coefficient;
    logic                  loader_busy;
    logic                  load_done;
    logic                  load_error;

    modport master (
        output new_coefficient_set,
        output coeff_mask,
        output modwait,
        input  load_coeff,
        input  coefficient_num,
        input  clear_coefficient,
        input  loader_busy,
        input  load_done,
        input  load_error
    );

    modport slave (
        input  new_coefficient_set,
        input  coeff_mask,
        input  modwait,
        output load_coeff,
        output coefficient_num,
        output clear_coefficient,
        output loader_busy,
        output load_done,
        output load_error
    );
endinterface

// File: rtl/coefficient_loader_n.sv
// Masked N-slot coefficient load sequencer with restart and modwait timeout.
module coefficient_loader_n #(
    parameter int NUM_COEFFS  = 4,
    parameter int CLEAR_AFTER = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    coefficient_loader_n_if.slave bus
);
    localparam int IDX_W = ($clog2(NUM_COEFFS) > 1) ? $clog2(NUM_COEFFS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam bit CLR_EN = (CLEAR_AFTER != 0);

    typedef enum logic [2:0] {
        IDLE, PREWAIT, LOAD, CHECK, CLEAR, ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [NUM_COEFFS-1:0] mask_q, mask_d;
    logic                  first_q, first_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [IDX_W:0]        first_hit, next_hit;
    logic                  tmo;

    // Lowest set bit at or above 'from'; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] find_from(
        input logic [NUM_COEFFS-1:0] m,
        input int                    from
    );
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_COEFFS - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    assign first_hit = find_from(bus.coeff_mask, 0);
    assign next_hit  = find_from(mask_q, int'(idx_q) + 1);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign tmo       = TMO_EN && ((int'(cnt_q) + 1) >= TIMEOUT);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        first_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        if (bus.new_coefficient_set) begin
            mask_d = bus.coeff_mask;
            err_d  = 1'b0;
            cnt_d  = '0;
            if (first_hit[IDX_W]) begin
                idx_d   = first_hit[IDX_W-1:0];
                state_d = PREWAIT;
            end else begin
                idx_d = '0;
                if (CLR_EN) begin
                    state_d = CLEAR;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                PREWAIT: begin
                    if (!bus.modwait) begin
                        state_d = LOAD;
                    end else if (tmo) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOAD: begin
                    state_d = CHECK;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
                CHECK: begin
                    // datapath raises modwait one cycle late, so skip the first look
                    if (first_q) begin
                        state_d = CHECK;
                    end else if (!bus.modwait) begin
                        if (next_hit[IDX_W]) begin
                            idx_d   = next_hit[IDX_W-1:0];
                            state_d = LOAD;
                        end else if (CLR_EN) begin
                            state_d = CLEAR;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (tmo) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                CLEAR: state_d = IDLE;
                ERROR: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.load_coeff        = (state_q == LOAD);
    assign bus.clear_coefficient = (state_q == CLEAR);
    assign bus.load_done         = (state_q == CLEAR) | done_q;
    assign bus.load_error        = err_q;
    assign bus.loader_busy       = (state_q == PREWAIT) | (state_q == LOAD) |
                                   (state_q == CHECK)   | (state_q == CLEAR);
    assign bus.coefficient_num   = ((state_q == PREWAIT) | (state_q == LOAD) |
                                    (state_q == CHECK)   | (state_q == ERROR))
                                   ? idx_q : '0;
endmodule

// File: tb/tb_coefficient_loader_n.sv
// Scoreboard bench for coefficient_loader_n: two instances (with/without clear).
module tb_coefficient_loader_n;
    localparam int N = 4;

    typedef enum int {EV_LOAD, EV_DONE, EV_ERR, EV_CLR} kind_t;
    typedef struct {
        kind_t kind;
        int    num;
        bit    clr;
        bit    busy;
        int    cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    string phase = "reset";
    exp_t  qa[$];
    exp_t  qb[$];

    coefficient_loader_n_if #(.NUM_COEFFS(N)) ifa ();
    coefficient_loader_n_if #(.NUM_COEFFS(N)) ifb ();

    coefficient_loader_n #(
        .NUM_COEFFS(N), .CLEAR_AFTER(1), .TIMEOUT(8)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    coefficient_loader_n #(
        .NUM_COEFFS(N), .CLEAR_AFTER(0), .TIMEOUT(0)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: modwait high for 3 negedges after each load
    int mw_left = 0;
    bit force_hi = 1'b0;
    bit stuck = 1'b0;
    int stuck_idx = -1;
    always @(negedge clk) begin
        if (ifa.load_coeff) mw_left = 3;
        else if (mw_left > 0) mw_left--;
        if (stuck_idx < 0) stuck = 1'b0;
        else if (ifa.load_coeff && int'(ifa.coefficient_num) == stuck_idx) stuck = 1'b1;
    end
    assign ifa.modwait = force_hi | stuck | (mw_left != 0);
    assign ifb.modwait = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic exp_t ev(kind_t k, int num, bit clr, bit busy, int c);
        exp_t e;
        e.kind = k; e.num = num; e.clr = clr; e.busy = busy; e.cyc = c;
        return e;
    endfunction

    function automatic exp_t observe(logic ld, logic dn, logic cl,
                                     logic bz, int num);
        kind_t k;
        k = ld ? EV_LOAD : dn ? EV_DONE : cl ? EV_CLR : EV_ERR;
        return ev(k, num, cl, bz, cyc);
    endfunction

    function automatic void cmp_ev(string tag, exp_t e, exp_t a);
        chk({tag, " kind"}, int'(a.kind), int'(e.kind));
        chk({tag, " num"}, a.num, e.num);
        chk({tag, " clear"}, int'(a.clr), int'(e.clr));
        chk({tag, " busy"}, int'(a.busy), int'(e.busy));
        chk({tag, " cycle"}, a.cyc, e.cyc);
    endfunction

    bit   err_prev_a = 1'b0;
    exp_t act_a;
    always @(negedge clk) begin
        if (ifa.load_coeff | ifa.load_done | ifa.clear_coefficient |
            (ifa.load_error & ~err_prev_a)) begin
            act_a = observe(ifa.load_coeff, ifa.load_done, ifa.clear_coefficient,
                            ifa.loader_busy, int'(ifa.coefficient_num));
            if (qa.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL A %s unexpected event kind %0d num %0d at cycle %0d",
                         phase, int'(act_a.kind), act_a.num, cyc);
            end else begin
                cmp_ev({"A ", phase}, qa.pop_front(), act_a);
            end
        end
        err_prev_a = ifa.load_error;
    end

    bit   err_prev_b = 1'b0;
    exp_t act_b;
    always @(negedge clk) begin
        if (ifb.load_coeff | ifb.load_done | ifb.clear_coefficient |
            (ifb.load_error & ~err_prev_b)) begin
            act_b = observe(ifb.load_coeff, ifb.load_done, ifb.clear_coefficient,
                            ifb.loader_busy, int'(ifb.coefficient_num));
            if (qb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL B %s unexpected event kind %0d num %0d at cycle %0d",
                         phase, int'(act_b.kind), act_b.num, cyc);
            end else begin
                cmp_ev({"B ", phase}, qb.pop_front(), act_b);
            end
        end
        err_prev_b = ifb.load_error;
    end

    task automatic req_a(input logic [N-1:0] m);
        ifa.new_coefficient_set = 1'b1;
        ifa.coeff_mask = m;
        @(negedge clk);
        ifa.new_coefficient_set = 1'b0;
        ifa.coeff_mask = ~m;
    endtask

    task automatic req_b(input logic [N-1:0] m);
        ifb.new_coefficient_set = 1'b1;
        ifb.coeff_mask = m;
        @(negedge clk);
        ifb.new_coefficient_set = 1'b0;
        ifb.coeff_mask = ~m;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({phase, " pending events"}, qa.size() + qb.size(), 0);
        qa.delete();
        qb.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic zero_a(input string tag);
        chk({tag, " A load_coeff"}, int'(ifa.load_coeff), 0);
        chk({tag, " A num"}, int'(ifa.coefficient_num), 0);
        chk({tag, " A clear"}, int'(ifa.clear_coefficient), 0);
        chk({tag, " A busy"}, int'(ifa.loader_busy), 0);
        chk({tag, " A done"}, int'(ifa.load_done), 0);
        chk({tag, " A error"}, int'(ifa.load_error), 0);
    endtask

    task automatic push_full_a(input int c);
        qa.push_back(ev(EV_LOAD, 0, 1'b0, 1'b1, c + 2));
        qa.push_back(ev(EV_LOAD, 1, 1'b0, 1'b1, c + 6));
        qa.push_back(ev(EV_LOAD, 2, 1'b0, 1'b1, c + 10));
        qa.push_back(ev(EV_LOAD, 3, 1'b0, 1'b1, c + 14));
        qa.push_back(ev(EV_DONE, 0, 1'b1, 1'b1, c + 18));
    endtask

    initial begin
        int c;
        int c2;
        ifa.new_coefficient_set = 1'b0; ifa.coeff_mask = '0;
        ifb.new_coefficient_set = 1'b0; ifb.coeff_mask = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        zero_a("reset");
        chk("reset B busy", int'(ifb.loader_busy), 0);
        chk("reset B done", int'(ifb.load_done), 0);
        @(negedge clk);

        phase = "t1 mask1111";
        c = cyc;
        push_full_a(c);
        req_a(4'b1111);
        drain(60);
        chk("t1 busy after done", int'(ifa.loader_busy), 0);

        phase = "t2 mask1010";
        c = cyc;
        qa.push_back(ev(EV_LOAD, 1, 1'b0, 1'b1, c + 2));
        qa.push_back(ev(EV_LOAD, 3, 1'b0, 1'b1, c + 6));
        qa.push_back(ev(EV_DONE, 0, 1'b1, 1'b1, c + 10));
        req_a(4'b1010);
        drain(40);

        phase = "t3 mask0";
        c = cyc;
        qa.push_back(ev(EV_DONE, 0, 1'b1, 1'b1, c + 1));
        req_a(4'b0000);
        drain(20);

        phase = "t4 prewait";
        force_hi = 1'b1;
        @(negedge clk);
        c = cyc;
        qa.push_back(ev(EV_LOAD, 0, 1'b0, 1'b1, c + 5));
        qa.push_back(ev(EV_DONE, 0, 1'b1, 1'b1, c + 9));
        req_a(4'b0001);
        repeat (3) @(negedge clk);
        chk("t4 busy in prewait", int'(ifa.loader_busy), 1);
        chk("t4 no load in prewait", int'(ifa.load_coeff), 0);
        force_hi = 1'b0;
        drain(30);

        phase = "t5 timeout";
        stuck_idx = 2;
        c = cyc;
        qa.push_back(ev(EV_LOAD, 0, 1'b0, 1'b1, c + 2));
        qa.push_back(ev(EV_LOAD, 1, 1'b0, 1'b1, c + 6));
        qa.push_back(ev(EV_LOAD, 2, 1'b0, 1'b1, c + 10));
        qa.push_back(ev(EV_ERR, 2, 1'b0, 1'b0, c + 20));
        req_a(4'b1111);
        drain(60);
        chk("t5 error held", int'(ifa.load_error), 1);
        chk("t5 busy in error", int'(ifa.loader_busy), 0);
        chk("t5 faulted idx", int'(ifa.coefficient_num), 2);
        stuck_idx = -1;
        repeat (2) @(negedge clk);
        phase = "t5 recover";
        c = cyc;
        push_full_a(c);
        req_a(4'b1111);
        chk("t5 error cleared", int'(ifa.load_error), 0);
        chk("t5 busy after restart", int'(ifa.loader_busy), 1);
        drain(60);

        phase = "t6 abort";
        c = cyc;
        qa.push_back(ev(EV_LOAD, 0, 1'b0, 1'b1, c + 2));
        qa.push_back(ev(EV_LOAD, 1, 1'b0, 1'b1, c + 6));
        qa.push_back(ev(EV_LOAD, 2, 1'b0, 1'b1, c + 10));
        req_a(4'b1111);
        repeat (10) @(negedge clk);
        c2 = cyc;
        qa.push_back(ev(EV_LOAD, 0, 1'b0, 1'b1, c2 + 3));
        qa.push_back(ev(EV_LOAD, 1, 1'b0, 1'b1, c2 + 7));
        qa.push_back(ev(EV_LOAD, 2, 1'b0, 1'b1, c2 + 11));
        qa.push_back(ev(EV_LOAD, 3, 1'b0, 1'b1, c2 + 15));
        qa.push_back(ev(EV_DONE, 0, 1'b1, 1'b1, c2 + 19));
        req_a(4'b1111);
        drain(60);

        phase = "t6 reset in load";
        c = cyc;
        qa.push_back(ev(EV_LOAD, 2, 1'b0, 1'b1, c + 2));
        req_a(4'b0100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        zero_a("t6 mid reset");
        reset = 1'b0;
        drain(20);

        phase = "t3b mask0 noclear";
        c = cyc;
        qb.push_back(ev(EV_DONE, 0, 1'b0, 1'b0, c + 1));
        req_b(4'b0000);
        drain(20);

        phase = "b mask0101";
        c = cyc;
        qb.push_back(ev(EV_LOAD, 0, 1'b0, 1'b1, c + 2));
        qb.push_back(ev(EV_LOAD, 2, 1'b0, 1'b1, c + 5));
        qb.push_back(ev(EV_DONE, 0, 1'b0, 1'b0, c + 8));
        req_b(4'b0101);
        drain(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, phase %s", phase);
        $fatal(1);
    end
endmodule
